uart_rx_frame_ctrl: RTL and testbench

UART_RX_FRAME_CTRL -- requirements
Module: uart_rx_frame_ctrl

---
 rtl/uart_rx_frame_ctrl_pkg.sv | 23 ++
 rtl/uart_frame_timer.sv | 28 ++
 rtl/uart_rx_frame_ctrl.sv | 131 +++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_frame_ctrl_pkg.sv
// Shared UART frame constants: receiver-side state encoding, default header
// byte and the frame checksum rule.
package uart_rx_frame_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GET_CMD  = 3'd1,
        GET_ADDR = 3'd2,
        GET_DATA = 3'd3,
        GET_CHK  = 3'd4
    } frame_state_t;

    localparam logic [7:0]  HEADER_DEFAULT  = 8'hAA;
    localparam logic [15:0] TIMEOUT_DEFAULT = 16'd20000;

    // Checksum byte expected at the end of a frame.
    function automatic logic [7:0] frame_chk(input logic [7:0] cmd,
                                             input logic [7:0] addr,
                                             input logic [7:0] data);
        return cmd ^ addr ^ data;
    endfunction

endpackage

// File: rtl/uart_frame_timer.sv
// Inter-byte timeout counter: saturating 16-bit up-counter with a
// combinational expire flag one count before the limit is reached.
module uart_frame_timer (
    input  logic        i_CLK,
    input  logic        w_rst,
    input  logic        clear,
    input  logic        enable,
    input  logic [15:0] limit,
    output logic        expire
);

    logic [15:0] count;

    // Count enabled cycles; clear has priority; hold at all-ones instead of wrapping.
    always_ff @(posedge i_CLK or posedge w_rst) begin
        if (w_rst) begin
            count <= 16'd0;
        end else if (clear) begin
            count <= 16'd0;
        end else if (enable && (count != 16'hFFFF)) begin
            count <= count + 16'd1;
        end
    end

    // A clear on the same cycle (new byte arrived) suppresses expiry.
    assign expire = enable && !clear && (count == (limit - 16'd1));

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART command frame decoder: HEADER, CMD, ADDR, DATA, CHK (XOR of payload).
// Good frames are presented on a valid/ready output; checksum, timeout and
// overrun conditions produce one-cycle error pulses.
//
// state    | meaning
// IDLE     | waiting for header byte, other bytes dropped
// GET_CMD  | next byte is the opcode
// GET_ADDR | next byte is the register address
// GET_DATA | next byte is the write data
// GET_CHK  | next byte is the checksum; frame completes here
module uart_rx_frame_ctrl
    import uart_rx_frame_ctrl_pkg::*;
#(
    parameter logic [7:0]  P_HEADER       = HEADER_DEFAULT,
    parameter logic [15:0] P_TIMEOUT_CLKS = TIMEOUT_DEFAULT
) (
    input  logic       i_CLK,
    input  logic       w_rst,
    input  logic       i_Rx_DV,
    input  logic [7:0] i_Rx_Byte,
    output logic       o_Cmd_Valid,
    input  logic       i_Cmd_Ready,
    output logic [7:0] o_Cmd,
    output logic [7:0] o_Addr,
    output logic [7:0] o_Data,
    output logic       o_Err_Chk,
    output logic       o_Err_Timeout,
    output logic       o_Err_Overrun,
    output logic       o_Busy
);

    frame_state_t state;
    logic [7:0]   sh_cmd;
    logic [7:0]   sh_addr;
    logic [7:0]   sh_data;
    logic         timer_enable;
    logic         timer_clear;
    logic         timer_expire;
    logic         chk_ok;
    logic         can_load;

    assign timer_enable = (state != IDLE);
    assign timer_clear  = !timer_enable || i_Rx_DV;
    assign chk_ok       = (i_Rx_Byte == frame_chk(sh_cmd, sh_addr, sh_data));
    // Output register is free if empty or being handed off this cycle.
    assign can_load     = !o_Cmd_Valid || i_Cmd_Ready;
    assign o_Busy       = (state != IDLE);

    uart_frame_timer u_timer (
        .i_CLK  (i_CLK),
        .w_rst  (w_rst),
        .clear  (timer_clear),
        .enable (timer_enable),
        .limit  (P_TIMEOUT_CLKS),
        .expire (timer_expire)
    );

    // Frame FSM with shadow capture, output register handshake and error pulses.
    always_ff @(posedge i_CLK or posedge w_rst) begin
        if (w_rst) begin
            state         <= IDLE;
            sh_cmd        <= 8'h00;
            sh_addr       <= 8'h00;
            sh_data       <= 8'h00;
            o_Cmd         <= 8'h00;
            o_Addr        <= 8'h00;
            o_Data        <= 8'h00;
            o_Cmd_Valid   <= 1'b0;
            o_Err_Chk     <= 1'b0;
            o_Err_Timeout <= 1'b0;
            o_Err_Overrun <= 1'b0;
        end else begin
            o_Err_Chk     <= 1'b0;
            o_Err_Timeout <= 1'b0;
            o_Err_Overrun <= 1'b0;

            if (o_Cmd_Valid && i_Cmd_Ready) begin
                o_Cmd_Valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (i_Rx_DV && (i_Rx_Byte == P_HEADER)) begin
                        state <= GET_CMD;
                    end
                end
                GET_CMD: begin
                    if (i_Rx_DV) begin
                        sh_cmd <= i_Rx_Byte;
                        state  <= GET_ADDR;
                    end
                end
                GET_ADDR: begin
                    if (i_Rx_DV) begin
                        sh_addr <= i_Rx_Byte;
                        state   <= GET_DATA;
                    end
                end
                GET_DATA: begin
                    if (i_Rx_DV) begin
                        sh_data <= i_Rx_Byte;
                        state   <= GET_CHK;
                    end
                end
                GET_CHK: begin
                    if (i_Rx_DV) begin
                        state <= IDLE;
                        if (!chk_ok) begin
                            o_Err_Chk <= 1'b1;
                        end else if (can_load) begin
                            o_Cmd       <= sh_cmd;
                            o_Addr      <= sh_addr;
                            o_Data      <= sh_data;
                            o_Cmd_Valid <= 1'b1;
                        end else begin
                            o_Err_Overrun <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // Expiry never coincides with a byte strobe (the strobe clears the timer).
            if (timer_expire) begin
                state         <= IDLE;
                o_Err_Timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed testbench for uart_rx_frame_ctrl. Inputs change and outputs are
// sampled on the falling clock edge.
module tb_uart_rx_frame_ctrl;

    logic       clk;
    logic       rst;
    logic       rx_dv;
    logic [7:0] rx_byte;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd;
    logic [7:0] addr;
    logic [7:0] data;
    logic       err_chk;
    logic       err_timeout;
    logic       err_overrun;
    logic       busy;

    int n_vec;
    int n_err;

    uart_rx_frame_ctrl #(
        .P_HEADER       (8'hAA),
        .P_TIMEOUT_CLKS (16'd20000)
    ) dut (
        .i_CLK         (clk),
        .w_rst         (rst),
        .i_Rx_DV       (rx_dv),
        .i_Rx_Byte     (rx_byte),
        .o_Cmd_Valid   (cmd_valid),
        .i_Cmd_Ready   (cmd_ready),
        .o_Cmd         (cmd),
        .o_Addr        (addr),
        .o_Data        (data),
        .o_Err_Chk     (err_chk),
        .o_Err_Timeout (err_timeout),
        .o_Err_Overrun (err_overrun),
        .o_Busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a falling edge; strobe is sampled at the next rising edge,
    // returns at the following falling edge where registered results are visible.
    task automatic send_byte(input logic [7:0] b);
        rx_dv   = 1'b1;
        rx_byte = b;
        @(negedge clk);
        rx_dv   = 1'b0;
        rx_byte = 8'h00;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_vec++; if ({cmd_valid, cmd, addr, data} !== 25'h0) begin n_err++; $display("FAIL reset_outputs: got valid=%b %h/%h/%h want 0 00/00/00", cmd_valid, cmd, addr, data); end
        n_vec++; if ({err_chk, err_timeout, err_overrun, busy} !== 4'b0) begin n_err++; $display("FAIL reset_flags: got %b want 0000", {err_chk, err_timeout, err_overrun, busy}); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_good_frame();
        cmd_ready = 1'b1;
        send_byte(8'hAA); send_byte(8'h01); send_byte(8'h10); send_byte(8'h5C);
        n_vec++; if (busy !== 1'b1 || cmd_valid !== 1'b0) begin n_err++; $display("FAIL good_midframe: got busy=%b valid=%b want 1 0", busy, cmd_valid); end
        send_byte(8'h4D);
        n_vec++; if (cmd_valid !== 1'b1) begin n_err++; $display("FAIL good_valid: got %b want 1", cmd_valid); end
        n_vec++; if ({cmd, addr, data} !== 24'h01105C) begin n_err++; $display("FAIL good_fields: got %h/%h/%h want 01/10/5C", cmd, addr, data); end
        n_vec++; if ({busy, err_chk, err_timeout, err_overrun} !== 4'b0) begin n_err++; $display("FAIL good_flags: got %b want 0000", {busy, err_chk, err_timeout, err_overrun}); end
        @(negedge clk);
        n_vec++; if (cmd_valid !== 1'b0) begin n_err++; $display("FAIL good_valid_clear: got %b want 0", cmd_valid); end
    endtask

    task automatic test_bad_chk();
        cmd_ready = 1'b1;
        send_byte(8'hAA); send_byte(8'h01); send_byte(8'h10); send_byte(8'h5C); send_byte(8'h4C);
        n_vec++; if (err_chk !== 1'b1 || cmd_valid !== 1'b0) begin n_err++; $display("FAIL badchk_pulse: got chk=%b valid=%b want 1 0", err_chk, cmd_valid); end
        n_vec++; if (err_timeout !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL badchk_state: got to=%b busy=%b want 0 0", err_timeout, busy); end
        @(negedge clk);
        n_vec++; if (err_chk !== 1'b0) begin n_err++; $display("FAIL badchk_width: got %b want 0", err_chk); end
        // 07^08^09 = 06
        send_byte(8'hAA); send_byte(8'h07); send_byte(8'h08); send_byte(8'h09); send_byte(8'h06);
        n_vec++; if (cmd_valid !== 1'b1 || {cmd, addr, data} !== 24'h070809) begin n_err++; $display("FAIL badchk_recover: got valid=%b %h/%h/%h want 1 07/08/09", cmd_valid, cmd, addr, data); end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        bit early;
        cmd_ready = 1'b1;
        send_byte(8'hAA); send_byte(8'h02);
        early = 1'b0;
        for (int i = 1; i <= 20000; i++) begin
            @(negedge clk);
            if (i < 20000 && (err_timeout !== 1'b0 || busy !== 1'b1)) early = 1'b1;
        end
        n_vec++; if (early !== 1'b0) begin n_err++; $display("FAIL timeout_early: got early=%b want 0", early); end
        n_vec++; if (err_timeout !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL timeout_pulse: got to=%b busy=%b want 1 0", err_timeout, busy); end
        n_vec++; if (err_chk !== 1'b0) begin n_err++; $display("FAIL timeout_nochk: got %b want 0", err_chk); end
        @(negedge clk);
        n_vec++; if (err_timeout !== 1'b0) begin n_err++; $display("FAIL timeout_width: got %b want 0", err_timeout); end
        // 05^06^07 = 04
        send_byte(8'hAA); send_byte(8'h05); send_byte(8'h06); send_byte(8'h07); send_byte(8'h04);
        n_vec++; if (cmd_valid !== 1'b1 || {cmd, addr, data} !== 24'h050607) begin n_err++; $display("FAIL timeout_recover: got valid=%b %h/%h/%h want 1 05/06/07", cmd_valid, cmd, addr, data); end
        @(negedge clk);
    endtask

    // Byte strobe lands exactly on the cycle the timer would expire.
    task automatic test_timeout_boundary();
        cmd_ready = 1'b1;
        send_byte(8'hAA); send_byte(8'h02);
        for (int i = 1; i <= 19999; i++) @(negedge clk);
        send_byte(8'h10);
        n_vec++; if (err_timeout !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL boundary_notimeout: got to=%b busy=%b want 0 1", err_timeout, busy); end
        // 02^10^5C = 4E
        send_byte(8'h5C); send_byte(8'h4E);
        n_vec++; if (cmd_valid !== 1'b1 || {cmd, addr, data} !== 24'h02105C) begin n_err++; $display("FAIL boundary_frame: got valid=%b %h/%h/%h want 1 02/10/5C", cmd_valid, cmd, addr, data); end
        @(negedge clk);
    endtask

    // Checksums follow the XOR rule: 02^20^33 = 11, 03^30^44 = 77.
    task automatic test_overrun();
        int ovr;
        cmd_ready = 1'b0;
        send_byte(8'hAA); send_byte(8'h02); send_byte(8'h20); send_byte(8'h33); send_byte(8'h11);
        n_vec++; if (cmd_valid !== 1'b1 || {cmd, addr, data} !== 24'h022033) begin n_err++; $display("FAIL ovr_first: got valid=%b %h/%h/%h want 1 02/20/33", cmd_valid, cmd, addr, data); end
        ovr = 0;
        send_byte(8'hAA); send_byte(8'h03); send_byte(8'h30); send_byte(8'h44); send_byte(8'h77);
        if (err_overrun === 1'b1) ovr++;
        n_vec++; if (err_overrun !== 1'b1) begin n_err++; $display("FAIL ovr_pulse: got %b want 1", err_overrun); end
        n_vec++; if (cmd_valid !== 1'b1 || {cmd, addr, data} !== 24'h022033) begin n_err++; $display("FAIL ovr_hold: got valid=%b %h/%h/%h want 1 02/20/33", cmd_valid, cmd, addr, data); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (err_overrun === 1'b1) ovr++;
        end
        n_vec++; if (ovr !== 1) begin n_err++; $display("FAIL ovr_count: got %0d want 1", ovr); end
        n_vec++; if (cmd_valid !== 1'b1 || {cmd, addr, data} !== 24'h022033) begin n_err++; $display("FAIL ovr_stable: got valid=%b %h/%h/%h want 1 02/20/33", cmd_valid, cmd, addr, data); end
        cmd_ready = 1'b1;
        @(negedge clk);
        n_vec++; if (cmd_valid !== 1'b0) begin n_err++; $display("FAIL ovr_transfer: got valid=%b want 0", cmd_valid); end
    endtask

    // New good frame completes on the same cycle as a handshake.
    task automatic test_back_to_back();
        cmd_ready = 1'b0;
        // 04^40^12 = 56
        send_byte(8'hAA); send_byte(8'h04); send_byte(8'h40); send_byte(8'h12); send_byte(8'h56);
        n_vec++; if (cmd_valid !== 1'b1 || cmd !== 8'h04) begin n_err++; $display("FAIL b2b_first: got valid=%b cmd=%h want 1 04", cmd_valid, cmd); end
        // 08^80^21 = A9
        send_byte(8'hAA); send_byte(8'h08); send_byte(8'h80); send_byte(8'h21);
        rx_dv = 1'b1; rx_byte = 8'hA9; cmd_ready = 1'b1;
        @(negedge clk);
        rx_dv = 1'b0; rx_byte = 8'h00;
        n_vec++; if (cmd_valid !== 1'b1 || {cmd, addr, data} !== 24'h088021) begin n_err++; $display("FAIL b2b_load: got valid=%b %h/%h/%h want 1 08/80/21", cmd_valid, cmd, addr, data); end
        n_vec++; if (err_overrun !== 1'b0) begin n_err++; $display("FAIL b2b_noovr: got %b want 0", err_overrun); end
        @(negedge clk);
        n_vec++; if (cmd_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain: got %b want 0", cmd_valid); end
    endtask

    task automatic test_header_payload();
        cmd_ready = 1'b1;
        send_byte(8'h55);
        n_vec++; if (busy !== 1'b0 || err_chk !== 1'b0) begin n_err++; $display("FAIL hdr_drop: got busy=%b chk=%b want 0 0", busy, err_chk); end
        for (int i = 0; i < 5; i++) send_byte(8'hAA);
        n_vec++; if (cmd_valid !== 1'b1 || {cmd, addr, data} !== 24'hAAAAAA) begin n_err++; $display("FAIL hdr_payload: got valid=%b %h/%h/%h want 1 AA/AA/AA", cmd_valid, cmd, addr, data); end
        @(negedge clk);
    endtask

    task automatic test_reset_midframe();
        // Reset with a command pending.
        cmd_ready = 1'b0;
        send_byte(8'hAA); send_byte(8'h01); send_byte(8'h10); send_byte(8'h5C); send_byte(8'h4D);
        send_byte(8'hAA); send_byte(8'h01);
        n_vec++; if (busy !== 1'b1 || cmd_valid !== 1'b1) begin n_err++; $display("FAIL rstmid_pre: got busy=%b valid=%b want 1 1", busy, cmd_valid); end
        rst = 1'b1;
        #1;
        n_vec++; if ({cmd_valid, cmd, addr, data, busy} !== 26'h0) begin n_err++; $display("FAIL rstmid_clear: got valid=%b %h/%h/%h busy=%b want all 0", cmd_valid, cmd, addr, data, busy); end
        @(negedge clk);
        rst = 1'b0;
        cmd_ready = 1'b1;
        @(negedge clk);
        send_byte(8'h10); send_byte(8'h5C); send_byte(8'h4D);
        n_vec++; if (cmd_valid !== 1'b0 || busy !== 1'b0 || err_chk !== 1'b0) begin n_err++; $display("FAIL rstmid_nocmd: got valid=%b busy=%b chk=%b want 0 0 0", cmd_valid, busy, err_chk); end
        @(negedge clk);
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        rx_dv     = 1'b0;
        rx_byte   = 8'h00;
        cmd_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_good_frame();
        test_bad_chk();
        test_timeout();
        test_timeout_boundary();
        test_overrun();
        test_back_to_back();
        test_header_payload();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
